// File: rtl/test_result_monitor.sv
// End-of-test monitor that snoops the register-file write port.
// It shadows the test-number, end-flag and result-flag registers.
// Once the end flag is seen, it waits a settle window and then latches a
// pass/fail verdict. A cycle-count timeout produces a separate verdict.
module test_result_monitor #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned END_REG       = 26,
    parameter int unsigned RESULT_REG    = 27,
    parameter int unsigned TESTNUM_REG   = 3,
    parameter int unsigned SETTLE_CYCLES = 10,
    parameter int unsigned TIMEOUT_BIT   = 20,
    parameter int unsigned TIMEOUT_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  rf_we_i,
    input  logic [4:0]            rf_waddr_i,
    input  logic [DATA_WIDTH-1:0] rf_wdata_i,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  timeout_o,
    output logic [DATA_WIDTH-1:0] testnum_o,
    output logic [31:0]           cycle_cnt_o
);

    localparam int unsigned SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [4:0]            END_ADDR   = 5'(END_REG);
    localparam logic [4:0]            RES_ADDR   = 5'(RESULT_REG);
    localparam logic [4:0]            TN_ADDR    = 5'(TESTNUM_REG);
    localparam logic [DATA_WIDTH-1:0] FLAG_ONE   = DATA_WIDTH'(1);
    localparam logic [SW-1:0]         SETTLE_LD  = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0]         SETTLE_ONE = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                state_q,      state_nx;
    logic [DATA_WIDTH-1:0] shadow_end_q, shadow_end_nx;
    logic [DATA_WIDTH-1:0] shadow_res_q, shadow_res_nx;
    logic [DATA_WIDTH-1:0] shadow_tn_q,  shadow_tn_nx;
    logic [31:0]           cycle_cnt_q,  cycle_cnt_nx;
    logic [SW-1:0]         settle_q,     settle_nx;
    logic                  done_q,       done_nx;
    logic                  pass_q,       pass_nx;
    logic                  fail_q,       fail_nx;
    logic                  timeout_q,    timeout_nx;
    logic [DATA_WIDTH-1:0] testnum_q,    testnum_nx;
    logic                  shadow_wr;
    logic                  timeout_hit;

    // Register x0 is never captured, and the shadows are frozen once the verdict is out.
    assign shadow_wr   = rf_we_i && (rf_waddr_i != '0) && (state_q != S_DONE);
    assign timeout_hit = (TIMEOUT_EN != 0) && cycle_cnt_q[TIMEOUT_BIT];

    // State, shadow, counter and verdict registers; async active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shadow_end_q <= '0;
            shadow_res_q <= '0;
            shadow_tn_q  <= '0;
            cycle_cnt_q  <= '0;
            settle_q     <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            testnum_q    <= '0;
        end else begin
            state_q      <= state_nx;
            shadow_end_q <= shadow_end_nx;
            shadow_res_q <= shadow_res_nx;
            shadow_tn_q  <= shadow_tn_nx;
            cycle_cnt_q  <= cycle_cnt_nx;
            settle_q     <= settle_nx;
            done_q       <= done_nx;
            pass_q       <= pass_nx;
            fail_q       <= fail_nx;
            timeout_q    <= timeout_nx;
            testnum_q    <= testnum_nx;
        end
    end

    // Next-state, shadow capture, counters and verdict latching; clear has top priority
    always_comb begin
        state_nx      = state_q;
        shadow_end_nx = shadow_end_q;
        shadow_res_nx = shadow_res_q;
        shadow_tn_nx  = shadow_tn_q;
        cycle_cnt_nx  = cycle_cnt_q;
        settle_nx     = settle_q;
        done_nx       = done_q;
        pass_nx       = pass_q;
        fail_nx       = fail_q;
        timeout_nx    = timeout_q;
        testnum_nx    = testnum_q;

        if (shadow_wr) begin
            if (rf_waddr_i == END_ADDR) shadow_end_nx = rf_wdata_i;
            if (rf_waddr_i == RES_ADDR) shadow_res_nx = rf_wdata_i;
            if (rf_waddr_i == TN_ADDR)  shadow_tn_nx  = rf_wdata_i;
        end

        if (clr_i) begin
            state_nx      = S_IDLE;
            shadow_end_nx = '0;
            shadow_res_nx = '0;
            shadow_tn_nx  = '0;
            cycle_cnt_nx  = '0;
            settle_nx     = '0;
            done_nx       = 1'b0;
            pass_nx       = 1'b0;
            fail_nx       = 1'b0;
            timeout_nx    = 1'b0;
            testnum_nx    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en_i) state_nx = S_RUN;
                end
                S_RUN: begin
                    // The end flag is checked first so it wins a same-cycle timeout.
                    // The timeout cycle itself is not counted, which leaves the
                    // counter holding exactly 2**TIMEOUT_BIT.
                    if (shadow_end_q == FLAG_ONE) begin
                        state_nx     = S_SETTLE;
                        settle_nx    = SETTLE_LD;
                        cycle_cnt_nx = cycle_cnt_q + 32'd1;
                    end else if (timeout_hit) begin
                        state_nx   = S_DONE;
                        done_nx    = 1'b1;
                        timeout_nx = 1'b1;
                        testnum_nx = shadow_tn_q;
                    end else begin
                        cycle_cnt_nx = cycle_cnt_q + 32'd1;
                    end
                end
                S_SETTLE: begin
                    cycle_cnt_nx = cycle_cnt_q + 32'd1;
                    if (settle_q == '0) begin
                        state_nx   = S_DONE;
                        done_nx    = 1'b1;
                        pass_nx    = (shadow_res_q == FLAG_ONE);
                        fail_nx    = (shadow_res_q != FLAG_ONE);
                        testnum_nx = shadow_tn_q;
                    end else begin
                        settle_nx = settle_q - SETTLE_ONE;
                    end
                end
                S_DONE: begin
                    state_nx = S_DONE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign testnum_o   = testnum_q;
    assign cycle_cnt_o = cycle_cnt_q;

endmodule
